seg7_bcd_fmt: RTL
=================

Name: seg7_bcd_fmt

Overview:
Sequential binary-to-BCD formatter that sits directly upstream of the 4-digit 7-segment display controller and drives that controller's 16-bit digit input `x`.
- Takes an unsigned binary measurement value on a start pulse.
- Converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- Registers the result as four packed nibbles, with an overflow code for values that do not fit.
- The display decoder renders nibble 0xA as a dash and 0xB as blank; this block relies on those codes.

Parameters:
WIDTH, 16, bit width of the binary input value; legal range 4..32.
OVF_LIMIT, 9999, largest value shown numerically; larger values display as dashes.

Ports:
clk  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
value  input  WIDTH  unsigned binary value; sampled only in the cycle start is accepted
start  input  1  conversion request; accepted only in IDLE
clr  input  1  synchronous abort of a running conversion
x  output  16  digit nibbles {d3,d2,d1,d0}, d0 least significant; feeds the display controller
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when x has just been updated
ovf  output  1  registered with x: 1 when the last converted value exceeded OVF_LIMIT

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, x=16'h0000, busy=0, done=0, ovf=0; internal shift register and bit counter cleared.
- FSM states:
  - IDLE: if start=1, latch value into the binary shift register, clear the 16-bit BCD accumulator, load the bit counter with WIDTH, latch ovf_next=(value>OVF_LIMIT), go to SHIFT. If start=0, stay in IDLE.
  - SHIFT: each cycle, every BCD nibble >=5 gets +3 (all four nibbles checked in parallel, 4-bit add, no carry between nibbles). Then the BCD accumulator shifts left one bit, taking in the binary register MSB; the binary register shifts left; the counter decrements. When the counter reaches 1 during this cycle, go to FMT.
  - FMT: x, ovf and done are registered (see below), then return to IDLE.
- Formatting in FMT:
  - If ovf_next=1: x=16'hAAAA (four dashes) and ovf=1. The accumulator contents are discarded; an overflowed accumulator is don't-care.
  - Otherwise: x = BCD accumulator and ovf=0.
- Latency: with start high in cycle n, busy is high in cycles n+1 .. n+WIDTH+1. Both x update and done=1 occur in cycle n+WIDTH+2 only.
- busy is a registered output: 1 in SHIFT and FMT, 0 in IDLE. done is low in every other cycle.
- start while busy=1 is ignored; no queueing.
- start in the same cycle as done is accepted, because the FSM is already back in IDLE.
- x holds its last value between conversions and is never changed mid-conversion.
- clr=1 in SHIFT or FMT: return to IDLE next cycle, busy=0, no done pulse, x and ovf unchanged.
- clr=1 in IDLE has no effect, and start is not accepted in that cycle (clr has priority).
- If WIDTH<=13, overflow is impossible and ovf stays 0.
- Reset asserted mid-conversion forces the reset values immediately; no done pulse is produced.

Optional Feature:
Macro SEG7_BCD_LZB_EN enables leading-zero blanking.
- Defined: in FMT, non-overflow results replace leading zero digits d3, then d2, then d1 with 4'hB (blank), scanning from d3 down and stopping at the first non-zero digit. d0 is never blanked. The 0xAAAA overflow pattern is unaffected. Example: 42 gives x=16'hBB42; 0 gives 16'hBBB0.
- Undefined: digits are passed through unmodified, so 42 gives 16'h0042.
- Timing and handshake are identical with or without the macro.

Test Plan:
- WIDTH=16, value=1234, start pulse in cycle n -> busy high cycles n+1..n+17; done=1 and x=16'h1234, ovf=0 in cycle n+18 only.
- value=9999 -> x=16'h9999, ovf=0. value=10000 -> x=16'hAAAA, ovf=1. value=16'hFFFF -> x=16'hAAAA, ovf=1.
- value=42, then value=0 -> x=16'h0042 then 16'h0000 without SEG7_BCD_LZB_EN; x=16'hBB42 then 16'hBBB0 with it.
- start=1 with value=5678 held during cycles n+3..n+10 of a 1234 conversion -> exactly one done, x=16'h1234. Then start with value=5678 in the done cycle -> accepted, giving x=16'h5678 after WIDTH+2 cycles.
- clr=1 in cycle n+5 of a conversion of 777 (previous x=16'h1234) -> busy=0 from n+6, no done, x stays 16'h1234.
- rst_ni low in cycle n+8 of a conversion -> x=16'h0000, busy=0, done=0 immediately; no done after release until a new start.

Source files
------------

// File: rtl/seg7_bcd_fmt_if.sv
// seg7_bcd_fmt_if: handshake and result bundle for the binary-to-BCD formatter.
//   value : unsigned binary value to convert (WIDTH bits)
//   start : conversion request
//   clr   : synchronous abort of a running conversion
//   x     : packed BCD digit nibbles {d3,d2,d1,d0} for the 7-segment controller
//   busy  : conversion in progress
//   done  : one-cycle pulse when x has just been updated
//   ovf   : last converted value did not fit in four digits
// master drives the request side; slave is the formatter.
interface seg7_bcd_fmt_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] value;
  logic             start;
  logic             clr;
  logic [15:0]      x;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (output value, start, clr, input x, busy, done, ovf);
  modport slave  (input value, start, clr, output x, busy, done, ovf);
endinterface

// File: rtl/seg7_bcd_fmt.sv
// seg7_bcd_fmt: sequential binary-to-BCD formatter feeding the 4-digit 7-segment
// display controller. A start pulse latches an unsigned value; a double-dabble
// engine converts one bit per clock; the result is registered as four packed
// nibbles. Values above OVF_LIMIT are shown as four dashes (nibble 0xA).
//
// Ports:
//   clk    : clock
//   rst_ni : asynchronous active-low reset
//   bus    : seg7_bcd_fmt_if.slave (value, start, clr in; x, busy, done, ovf out)
//
// Optional build macro SEG7_BCD_LZB_EN: blank leading zero digits d3..d1 with
// nibble 0xB in non-overflow results (d0 is never blanked).
module seg7_bcd_fmt #(
  parameter int WIDTH     = 16,
  parameter int OVF_LIMIT = 9999
) (
  input logic           clk,
  input logic           rst_ni,
  seg7_bcd_fmt_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FMT   = 2'd2
  } state_e;

  state_e           state_r;
  logic [WIDTH-1:0] bin_r;
  logic [15:0]      bcd_r;
  logic [CW-1:0]    cnt_r;
  logic             ovf_next_r;
  logic [15:0]      x_r;
  logic             busy_r;
  logic             done_r;
  logic             ovf_r;

  logic [15:0]      bcd_step_s;
  logic [15:0]      fmt_s;
  logic             ovf_in_s;

  // One double-dabble step: correct every nibble >=5 by +3, then shift in the next bit.
  function automatic logic [15:0] dabble_step(input logic [15:0] bcd, input logic in_bit);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        adj[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return (adj << 1) | {15'd0, in_bit};
  endfunction

`ifdef SEG7_BCD_LZB_EN
  // Replace leading zero digits d3, d2, d1 with blank (0xB), stopping at the first non-zero.
  function automatic logic [15:0] blank_leading(input logic [15:0] bcd);
    logic [15:0] r;
    logic        lead;
    r    = bcd;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (bcd[i*4 +: 4] == 4'd0)) begin
        r[i*4 +: 4] = 4'hB;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction
`endif

  // Next-step datapath values and the overflow decision on the incoming value.
  always_comb begin
    bcd_step_s = dabble_step(bcd_r, bin_r[WIDTH-1]);
`ifdef SEG7_BCD_LZB_EN
    fmt_s      = blank_leading(bcd_r);
`else
    fmt_s      = bcd_r;
`endif
    // Zero-extend both sides to 64 bits so any legal WIDTH compares correctly.
    ovf_in_s   = ({{(64-WIDTH){1'b0}}, bus.value} > 64'(OVF_LIMIT));
  end

  // Conversion FSM with registered result and handshake outputs.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      bin_r      <= '0;
      bcd_r      <= 16'h0000;
      cnt_r      <= '0;
      ovf_next_r <= 1'b0;
      x_r        <= 16'h0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // clr wins over start while idle.
          if (!bus.clr && bus.start) begin
            bin_r      <= bus.value;
            bcd_r      <= 16'h0000;
            cnt_r      <= CW'(WIDTH);
            ovf_next_r <= ovf_in_s;
            busy_r     <= 1'b1;
            state_r    <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (bus.clr) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            bcd_r <= bcd_step_s;
            bin_r <= bin_r << 1;
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
              state_r <= ST_FMT;
            end else begin
              state_r <= ST_SHIFT;
            end
          end
        end
        ST_FMT: begin
          if (bus.clr) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            // An overflowed accumulator is meaningless; show dashes instead.
            x_r     <= ovf_next_r ? 16'hAAAA : fmt_s;
            ovf_r   <= ovf_next_r;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.x    = x_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.ovf  = ovf_r;

endmodule
